m68k_bus_target: RTL



---
 rtl/m68k_bus_pkg.sv | 27 ++
 rtl/m68k_bus_target_edge_sync.sv | 29 ++
 rtl/m68k_bus_target.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared types and helpers for the 68000 bus target: FSM encoding, synchroniser depth, byte merge.
package m68k_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MISS,
    ST_ACCESS,
    ST_WAIT,
    ST_HOLD
  } state_t;

  localparam int SYNC_DEPTH = 3;
  localparam int WAIT_CNT_W = 8;

  // Replace only the byte lanes whose data strobe was asserted.
  function automatic logic [15:0] byte_merge(input logic [15:0] old_w,
                                             input logic [15:0] new_w,
                                             input logic        uds_n,
                                             input logic        lds_n);
    logic [15:0] m;
    m = old_w;
    if (!uds_n) m[15:8] = new_w[15:8];
    if (!lds_n) m[7:0]  = new_w[7:0];
    return m;
  endfunction

endpackage

// File: rtl/m68k_bus_target_edge_sync.sv
// N-flop synchroniser; q is the two-flop synchronised level, rise/fall are one-cycle edge pulses.
module m68k_edge_sync
  import m68k_bus_pkg::*;
#(
  parameter int   N       = SYNC_DEPTH,
  parameter logic RST_VAL = 1'b0
) (
  input  logic c200m,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [N-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[N-2:0], d};

  always_ff @(posedge c200m) begin
    if (reset) sync_q <= {N{RST_VAL}};
    else       sync_q <= sync_d;
  end

  assign q    = sync_q[N-2];
  assign rise = sync_q[N-2] & ~sync_q[N-1];
  assign fall = ~sync_q[N-2] & sync_q[N-1];

endmodule

// File: rtl/m68k_bus_target.sv
// 68000 bus responder: window decode, word register file, DTACK after programmable 7 MHz waits.
// Optional macro TARGET_VPA_EN replaces DTACK with a 6800-style VPA/VMA/E cycle on hits.
module m68k_bus_target
  import m68k_bus_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR   = 24'hE80000,
  parameter int          ADDR_BITS   = 4,
  parameter int          WAIT_STATES = 2
) (
  input  logic                 c200m,
  input  logic                 reset,
  input  logic                 M68K_CLK,
  input  logic [23:1]          M68K_A,
  input  logic                 M68K_AS_n,
  input  logic                 M68K_UDS_n,
  input  logic                 M68K_LDS_n,
  input  logic                 M68K_RW,
  input  logic [15:0]          M68K_D_in,
  output logic [15:0]          M68K_D_out,
  output logic                 M68K_D_oe,
  output logic                 M68K_DTACK_n,
`ifdef TARGET_VPA_EN
  output logic                 M68K_VPA_n,
  input  logic                 M68K_VMA_n,
  input  logic                 M68K_E,
`endif
  output logic                 wr_stb,
  output logic [ADDR_BITS-1:0] wr_idx,
  output logic [15:0]          wr_data
);

  localparam int NWORDS = 2**ADDR_BITS;

  logic clk_rise, clk_fall, as_s, as_rise, as_fall;
  logic [1:0][2:0] strb_q, strb_d;
  logic uds_s, lds_s, rw_s, hit;
  logic [ADDR_BITS-1:0] a_idx;

  m68k_edge_sync #(.N(SYNC_DEPTH), .RST_VAL(1'b0)) u_clk_sync (
    .c200m(c200m), .reset(reset), .d(M68K_CLK), .q(), .rise(clk_rise), .fall(clk_fall));
  m68k_edge_sync #(.N(SYNC_DEPTH), .RST_VAL(1'b1)) u_as_sync (
    .c200m(c200m), .reset(reset), .d(M68K_AS_n), .q(as_s), .rise(as_rise), .fall(as_fall));

  state_t                 state_q, state_d;
  logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   acc_idx_q, acc_idx_d;
  logic                   acc_rd_q, acc_rd_d, acc_uds_n_q, acc_uds_n_d, acc_lds_n_q, acc_lds_n_d;
  logic [15:0]            acc_din_q, acc_din_d, dout_q, dout_d, merged;
  logic                   doe_q, doe_d, dtack_n_q, dtack_n_d, wr_stb_q, wr_stb_d;
  logic [ADDR_BITS-1:0]   wr_idx_q, wr_idx_d;
  logic [15:0]            wr_data_q, wr_data_d;
  logic [15:0]            rf_q [NWORDS];
  logic [15:0]            rf_d [NWORDS];

`ifdef TARGET_VPA_EN
  logic e_rise, e_fall, vma_s, vpa_n_q, vpa_n_d, vma_seen_q, vma_seen_d;
  logic [1:0] vma_q, vma_d;
  logic unused_edges;
  m68k_edge_sync #(.N(SYNC_DEPTH), .RST_VAL(1'b0)) u_e_sync (
    .c200m(c200m), .reset(reset), .d(M68K_E), .q(), .rise(e_rise), .fall(e_fall));
  assign vma_d = {vma_q[0], M68K_VMA_n};
  assign vma_s = vma_q[1];
  assign unused_edges = ^{clk_rise, clk_fall, as_rise, as_fall, e_rise};
`else
  logic unused_edges;
  assign unused_edges = ^{clk_rise, as_rise, as_fall};
`endif

  assign strb_d = {strb_q[0], {M68K_UDS_n, M68K_LDS_n, M68K_RW}};
  assign {uds_s, lds_s, rw_s} = strb_q[1];
  assign hit   = (M68K_A[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);
  assign a_idx = M68K_A[ADDR_BITS:1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_idx_d   = acc_idx_q;
    acc_rd_d    = acc_rd_q;
    acc_uds_n_d = acc_uds_n_q;
    acc_lds_n_d = acc_lds_n_q;
    acc_din_d   = acc_din_q;
    dout_d      = dout_q;
    doe_d       = doe_q;
    dtack_n_d   = dtack_n_q;
    wr_stb_d    = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    rf_d        = rf_q;
    merged      = byte_merge(rf_q[acc_idx_q], acc_din_q, acc_uds_n_q, acc_lds_n_q);
`ifdef TARGET_VPA_EN
    vpa_n_d     = vpa_n_q;
    vma_seen_d  = vma_seen_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Address and write data are stable once the synchronised strobes are low.
        if (!as_s && (!uds_s || !lds_s)) begin
          acc_idx_d   = a_idx;
          acc_rd_d    = rw_s;
          acc_uds_n_d = uds_s;
          acc_lds_n_d = lds_s;
          acc_din_d   = M68K_D_in;
          state_d     = hit ? ST_ACCESS : ST_MISS;
        end
      end
      ST_MISS: if (as_s) state_d = ST_IDLE;
      ST_ACCESS: begin
        if (acc_rd_q) begin
          dout_d = rf_q[acc_idx_q];
          doe_d  = 1'b1;
        end else begin
          rf_d[acc_idx_q] = merged;
          wr_stb_d        = 1'b1;
          wr_idx_d        = acc_idx_q;
          wr_data_d       = merged;
        end
        cnt_d = WAIT_CNT_W'(WAIT_STATES);
`ifdef TARGET_VPA_EN
        vpa_n_d    = 1'b0;
        vma_seen_d = 1'b0;
`endif
        if (as_s) begin
          doe_d   = 1'b0;
`ifdef TARGET_VPA_EN
          vpa_n_d = 1'b1;
`endif
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (as_s) begin
          doe_d   = 1'b0;
`ifdef TARGET_VPA_EN
          vpa_n_d = 1'b1;
`endif
          state_d = ST_IDLE;
`ifdef TARGET_VPA_EN
        end else if (vma_seen_q && e_fall) begin
          state_d = ST_HOLD;
        end else if (!vma_s) begin
          vma_seen_d = 1'b1;
`else
        end else if (clk_fall) begin
          if (cnt_q == '0) begin
            dtack_n_d = 1'b0;
            state_d   = ST_HOLD;
          end else begin
            cnt_d = cnt_q - WAIT_CNT_W'(1);
          end
`endif
        end
      end
      ST_HOLD: begin
        if (as_s) begin
          dtack_n_d = 1'b1;
          doe_d     = 1'b0;
`ifdef TARGET_VPA_EN
          vpa_n_d   = 1'b1;
`endif
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge c200m) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      strb_q      <= '1;
      cnt_q       <= '0;
      acc_idx_q   <= '0;
      acc_rd_q    <= 1'b1;
      acc_uds_n_q <= 1'b1;
      acc_lds_n_q <= 1'b1;
      acc_din_q   <= '0;
      dout_q      <= '0;
      doe_q       <= 1'b0;
      dtack_n_q   <= 1'b1;
      wr_stb_q    <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < NWORDS; i++) rf_q[i] <= '0;
`ifdef TARGET_VPA_EN
      vma_q       <= '1;
      vpa_n_q     <= 1'b1;
      vma_seen_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      strb_q      <= strb_d;
      cnt_q       <= cnt_d;
      acc_idx_q   <= acc_idx_d;
      acc_rd_q    <= acc_rd_d;
      acc_uds_n_q <= acc_uds_n_d;
      acc_lds_n_q <= acc_lds_n_d;
      acc_din_q   <= acc_din_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
      dtack_n_q   <= dtack_n_d;
      wr_stb_q    <= wr_stb_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      rf_q        <= rf_d;
`ifdef TARGET_VPA_EN
      vma_q       <= vma_d;
      vpa_n_q     <= vpa_n_d;
      vma_seen_q  <= vma_seen_d;
`endif
    end
  end

  assign M68K_D_out   = dout_q;
  assign M68K_D_oe    = doe_q;
  assign M68K_DTACK_n = dtack_n_q;
  assign wr_stb       = wr_stb_q;
  assign wr_idx       = wr_idx_q;
  assign wr_data      = wr_data_q;
`ifdef TARGET_VPA_EN
  assign M68K_VPA_n   = vpa_n_q;
`endif

endmodule
